// File: rtl/cmd_arbiter_if.sv
// Requester, status and sender-control signals of cmd_arbiter, grouped into one bundle.
// slave is the arbiter side; master is the requesters plus the serial command sender.
interface cmd_arbiter_if;
  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;

  logic              req0;
  logic              req1;
  logic [CMD_W-1:0]  cmd0;
  logic [CMD_W-1:0]  cmd1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [RESP_W-1:0] resp_out;
  logic              timeout;
  logic              busy;
  logic              send_cmd;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_sent;
  logic              resp_rdy;
  logic [RESP_W-1:0] resp;
  logic              clr_resp_rdy;

  modport slave (
    input  req0, req1, cmd0, cmd1, cmd_sent, resp_rdy, resp,
    output gnt0, gnt1, done0, done1, resp_out, timeout, busy,
           send_cmd, cmd, clr_resp_rdy
  );

  modport master (
    output req0, req1, cmd0, cmd1, cmd_sent, resp_rdy, resp,
    input  gnt0, gnt1, done0, done1, resp_out, timeout, busy,
           send_cmd, cmd, clr_resp_rdy
  );
endinterface

// File: rtl/cmd_arbiter.sv
// Two-requester round-robin arbiter that forwards one command at a time to a serial
// command sender and returns its response byte, abandoning stalled transactions.
module cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic         clk,
  input  logic         rst_n,
  cmd_arbiter_if.slave arb_if
);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;
  localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_RESP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CMD_W-1:0]    r_cmd;
  logic [RESP_W-1:0]   r_resp_out;
  logic                r_owner;
  logic                r_prio;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_done0;
  logic                r_done1;
  logic                r_timeout;
  logic                r_busy;
  logic                r_send_cmd;
  logic                r_clr_resp_rdy;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [CMD_W-1:0]    w_cmd_nxt;
  logic [RESP_W-1:0]   w_resp_out_nxt;
  logic                w_owner_nxt;
  logic                w_prio_nxt;
  logic                w_win;
  logic                w_expired;
  logic                w_finish;
  logic                w_gnt0_nxt;
  logic                w_gnt1_nxt;
  logic                w_done0_nxt;
  logic                w_done1_nxt;
  logic                w_timeout_nxt;
  logic                w_busy_nxt;
  logic                w_send_cmd_nxt;
  logic                w_clr_resp_rdy_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_cmd          <= '0;
      r_resp_out     <= '0;
      r_owner        <= 1'b0;
      r_prio         <= 1'b0;
      r_gnt0         <= 1'b0;
      r_gnt1         <= 1'b0;
      r_done0        <= 1'b0;
      r_done1        <= 1'b0;
      r_timeout      <= 1'b0;
      r_busy         <= 1'b0;
      r_send_cmd     <= 1'b0;
      r_clr_resp_rdy <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_cmd          <= w_cmd_nxt;
      r_resp_out     <= w_resp_out_nxt;
      r_owner        <= w_owner_nxt;
      r_prio         <= w_prio_nxt;
      r_gnt0         <= w_gnt0_nxt;
      r_gnt1         <= w_gnt1_nxt;
      r_done0        <= w_done0_nxt;
      r_done1        <= w_done1_nxt;
      r_timeout      <= w_timeout_nxt;
      r_busy         <= w_busy_nxt;
      r_send_cmd     <= w_send_cmd_nxt;
      r_clr_resp_rdy <= w_clr_resp_rdy_nxt;
    end
  end

  // Next state, datapath updates and output pulses
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_cmd_nxt          = r_cmd;
    w_resp_out_nxt     = r_resp_out;
    w_owner_nxt        = r_owner;
    w_prio_nxt         = r_prio;
    w_win              = 1'b0;
    w_finish           = 1'b0;
    w_gnt0_nxt         = 1'b0;
    w_gnt1_nxt         = 1'b0;
    w_timeout_nxt      = 1'b0;
    w_send_cmd_nxt     = 1'b0;
    w_clr_resp_rdy_nxt = 1'b0;
    w_expired          = (r_cnt >= CNT_EXPIRE);
    w_cnt_inc          = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    case (r_state)
      ST_IDLE: begin
        if (arb_if.req0 || arb_if.req1) begin
          // Contention goes to r_prio, the requester not granted last
          w_win       = (arb_if.req0 && arb_if.req1) ? r_prio : arb_if.req1;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_cmd_nxt   = w_win ? arb_if.cmd1 : arb_if.cmd0;
          w_owner_nxt = w_win;
          w_prio_nxt  = ~w_win;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_send_cmd_nxt     = 1'b1;
        w_clr_resp_rdy_nxt = 1'b1;
        w_cnt_nxt          = '0;
        w_state_nxt        = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        w_cnt_nxt = w_cnt_inc;
        if (arb_if.cmd_sent) begin
          w_state_nxt = ST_WAIT_RESP;
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_finish      = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_WAIT_RESP: begin
        w_cnt_nxt = w_cnt_inc;
        // A response in the expiry cycle still counts as a normal completion
        if (arb_if.resp_rdy) begin
          w_resp_out_nxt     = arb_if.resp;
          w_clr_resp_rdy_nxt = 1'b1;
          w_finish           = 1'b1;
          w_state_nxt        = ST_IDLE;
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_finish      = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_done0_nxt = w_finish & ~r_owner;
    w_done1_nxt = w_finish & r_owner;
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  assign arb_if.gnt0         = r_gnt0;
  assign arb_if.gnt1         = r_gnt1;
  assign arb_if.done0        = r_done0;
  assign arb_if.done1        = r_done1;
  assign arb_if.resp_out     = r_resp_out;
  assign arb_if.timeout      = r_timeout;
  assign arb_if.busy         = r_busy;
  assign arb_if.send_cmd     = r_send_cmd;
  assign arb_if.cmd          = r_cmd;
  assign arb_if.clr_resp_rdy = r_clr_resp_rdy;
endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 20000, meaning the number of cycles allowed from send_cmd to resp_rdy before the transaction is abandoned (legal range 4..65535).
REQ-002 The module SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n as elsewhere in the codebase.
REQ-003 Port clk  input  1  system clock, all state on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Ports req0, req1  input  1 each  requester asks for a transaction; held high until granted.
REQ-006 Ports cmd0, cmd1  input  16 each  command word of each requester, valid while its req is high.
REQ-007 Ports gnt0, gnt1  output  1 each  one-cycle pulse: request accepted and command captured.
REQ-008 Ports done0, done1  output  1 each  one-cycle pulse: the granted transaction finished (response or timeout).
REQ-009 Port resp_out  output  8  last response byte, valid from the done pulse until the next done pulse.
REQ-010 Port timeout  output  1  one-cycle pulse, coincident with done, when the transaction timed out.
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Ports send_cmd  output  1, cmd  output  16  drive the serial command sender.
REQ-013 Ports cmd_sent  input  1, resp_rdy  input  1, resp  input  8  status from the serial command sender.
REQ-014 Port clr_resp_rdy  output  1  one-cycle pulse to clear the sender's response-ready flag.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, WAIT_SENT, WAIT_RESP.
REQ-016 In IDLE with at least one req high, the FSM SHALL grant one requester: a single req wins; with both high, the requester not granted last wins; after reset requester 0 is favoured.
REQ-017 In the grant cycle, the FSM SHALL pulse the matching gnt, register the winner's cmd into the cmd output register, record the winner's index, and move to SEND.
REQ-018 cmd SHALL hold the captured word from the cycle after the grant until return to IDLE; requesters may change cmdX or drop reqX after gnt.
REQ-019 In SEND, which lasts exactly one cycle, the FSM SHALL assert send_cmd=1 and clr_resp_rdy=1 (flushing any stale response), clear the timeout counter, and move to WAIT_SENT.
REQ-020 In WAIT_SENT, the FSM SHALL move to WAIT_RESP on cmd_sent=1; cmd_sent is not sampled in SEND.
REQ-021 In WAIT_RESP with resp_rdy=1, the FSM SHALL register resp into resp_out, pulse clr_resp_rdy, pulse done of the recorded requester, and return to IDLE.
REQ-022 A 16-bit counter SHALL increment every cycle in WAIT_SENT and WAIT_RESP and SHALL saturate rather than wrap.
REQ-023 When the counter equals TIMEOUT_CYC-1 without the completing event, the FSM SHALL pulse timeout and the recorded requester's done, leave resp_out unchanged, and return to IDLE.
REQ-024 If resp_rdy=1 in the same cycle as timeout expiry, the response SHALL win and timeout SHALL stay 0.
REQ-025 Requests arriving while busy=1 SHALL wait; arbitration occurs only in IDLE, so the earliest re-grant is the cycle after a done pulse.
REQ-026 send_cmd, clr_resp_rdy, gnt*, done*, and timeout SHALL each be high for exactly one cycle per event and never otherwise.

Reset
REQ-027 Asserting rst_n=0 at any time, including mid-transaction, SHALL immediately force IDLE, counter=0, cmd=16'h0000, resp_out=8'h00, all pulse outputs and busy to 0, and the round-robin pointer to favour requester 0.
REQ-028 After reset release, no done pulse SHALL be issued for a transaction aborted by reset.

Verification
REQ-029 The bench SHALL cover: req0=1, cmd0=16'hA55A, sender model returns resp=8'h3C -> gnt0 pulse, send_cmd one cycle later with cmd=A55A, done0 pulse with resp_out=8'h3C, busy returns to 0.
REQ-030 The bench SHALL cover: req0 and req1 high continuously for 4 transactions -> grants alternate 0,1,0,1 and no gnt occurs while busy=1.
REQ-031 The bench SHALL cover: TIMEOUT_CYC=16, sender never raises resp_rdy -> timeout and done pulse together 16 cycles after send_cmd, and resp_out keeps its previous value.
REQ-032 The bench SHALL cover: resp_rdy raised exactly in the expiry cycle -> done with resp_out updated, timeout=0.
REQ-033 The bench SHALL cover: rst_n pulsed low while in WAIT_RESP -> all outputs are 0 within the same cycle, no done pulse follows, and the next req1-only request is granted normally.
REQ-034 The bench SHALL cover: changing cmd0 to 16'hFFFF right after gnt0 -> cmd output stays at the captured value through done0.
